// File: rtl/imem_scanner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_scanner : walks a synchronous-read memory between two bounds on a
//                prescaled tick or on step pulses.  Rev 1.0
// ---------------------------------------------------------------------------
module imem_scanner #(
   parameter int ADDR_W  = 3,
   parameter int DATA_W  = 32,
   parameter int DIV     = 4,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic              i_step,
   input  logic [1:0]        i_mode,
   input  logic [ADDR_W-1:0] i_start_addr,
   input  logic [ADDR_W-1:0] i_end_addr,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic [DATA_W-1:0] i_mem_data,
   output logic [DATA_W-1:0] o_data_out,
   output logic [ADDR_W-1:0] o_data_addr,
   output logic              o_data_valid,
   output logic              o_busy,
   output logic              o_done,
   output logic [7:0]        o_wrap_cnt
);

   localparam int              c_PW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int              c_LW        = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(DIV - 1);
   localparam logic [c_LW-1:0] c_LAT_MAX   = c_LW'(MEM_LAT - 1);
   localparam logic [1:0]      c_MODE_WRAP = 2'd0;
   localparam logic [1:0]      c_MODE_STEP = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

   state_t            r_state, w_state_nxt;
   logic [1:0]        r_mode;
   logic [ADDR_W-1:0] r_start, r_end, r_mem_addr, r_data_addr;
   logic [DATA_W-1:0] r_data_out;
   logic [c_PW-1:0]   r_presc;
   logic [c_LW-1:0]   r_lat;
   logic              r_valid;
   logic [7:0]        r_wrap;

   logic w_tick, w_start_ok, w_issue, w_capture, w_at_end, w_is_wrap;

   assign w_tick     = (r_presc == c_PRESC_MAX);
   assign w_is_wrap  = (r_mode == c_MODE_WRAP);
   assign w_start_ok = i_start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_issue    = (r_state == S_RUN) &&
                       ((r_mode == c_MODE_STEP) ? i_step : w_tick);
   assign w_capture  = (r_state == S_WAIT) && (r_lat == c_LAT_MAX);
   assign w_at_end   = (r_mem_addr == r_end);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      o_busy      = (r_state == S_RUN) || (r_state == S_WAIT);
      o_done      = (r_state == S_DONE);
      if (i_stop) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: if (i_start) w_state_nxt = S_RUN;
            S_RUN:          if (w_issue) w_state_nxt = S_WAIT;
            S_WAIT: begin
               if (w_capture)
                  w_state_nxt = (!w_at_end || w_is_wrap) ? S_RUN : S_DONE;
            end
            default:        w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Stop outranks everything, so a capture on the stop edge is discarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode      <= '0;
         r_start     <= '0;
         r_end       <= '0;
         r_mem_addr  <= '0;
         r_data_addr <= '0;
         r_data_out  <= '0;
         r_presc     <= '0;
         r_lat       <= '0;
         r_valid     <= 1'b0;
         r_wrap      <= '0;
      end else begin
         r_valid <= 1'b0;
         if (i_stop) begin
            r_presc <= '0;
         end else if (w_start_ok) begin
            r_mode     <= i_mode;
            r_start    <= i_start_addr;
            r_end      <= i_end_addr;
            r_mem_addr <= i_start_addr;
            r_presc    <= '0;
            r_wrap     <= '0;
         end else begin
            if (r_state == S_RUN)
               r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_issue)
               r_lat <= '0;
            else if (r_state == S_WAIT)
               r_lat <= r_lat + 1'b1;
            if (w_capture) begin
               r_data_out  <= i_mem_data;
               r_data_addr <= r_mem_addr;
               r_valid     <= 1'b1;
               r_presc     <= '0;
               if (!w_at_end) begin
                  r_mem_addr <= r_mem_addr + 1'b1;
               end else if (w_is_wrap) begin
                  r_mem_addr <= r_start;
                  if (r_wrap != 8'hFF) r_wrap <= r_wrap + 1'b1;
               end
            end
         end
      end
   end

   assign o_mem_addr   = r_mem_addr;
   assign o_data_out   = r_data_out;
   assign o_data_addr  = r_data_addr;
   assign o_data_valid = r_valid;
   assign o_wrap_cnt   = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_imem_scanner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_imem_scanner : directed bench for imem_scanner (DIV=4/LAT=1 and
//                   DIV=1/LAT=3 instances sharing one stimulus).  Rev 1.0
// ---------------------------------------------------------------------------
module tb_imem_scanner;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, stop = 1'b0, step = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [2:0]  s_addr = 3'd0, e_addr = 3'd0;

   logic [2:0]  a_mem_addr, a_data_addr, b_mem_addr, b_data_addr;
   logic [31:0] a_mem_data, a_data_out, b_data_out;
   logic        a_valid, a_busy, a_done, b_valid, b_busy, b_done;
   logic [7:0]  a_wrap, b_wrap;
   logic [31:0] b_s1 = '0, b_s2 = '0, b_s3 = '0;

   int n_chk = 0, n_pass = 0, cyc_n = 0;
   logic [2:0]  qa_addr[$];
   logic [31:0] qa_data[$];
   logic [7:0]  qa_wrap[$];
   int          qa_cyc[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [2:0] a);
      return {29'd0, a} * 32'h11;
   endfunction

   always @(posedge clk) begin
      a_mem_data <= mem_word(a_mem_addr);
      b_s1 <= mem_word(b_mem_addr);
      b_s2 <= b_s1;
      b_s3 <= b_s2;
   end

   imem_scanner #(.ADDR_W(3), .DATA_W(32), .DIV(4), .MEM_LAT(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .i_start(start), .i_stop(stop), .i_step(step),
      .i_mode(mode), .i_start_addr(s_addr), .i_end_addr(e_addr),
      .o_mem_addr(a_mem_addr), .i_mem_data(a_mem_data), .o_data_out(a_data_out),
      .o_data_addr(a_data_addr), .o_data_valid(a_valid), .o_busy(a_busy),
      .o_done(a_done), .o_wrap_cnt(a_wrap));

   imem_scanner #(.ADDR_W(3), .DATA_W(32), .DIV(1), .MEM_LAT(3)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .i_start(start), .i_stop(stop), .i_step(step),
      .i_mode(mode), .i_start_addr(s_addr), .i_end_addr(e_addr),
      .o_mem_addr(b_mem_addr), .i_mem_data(b_s3), .o_data_out(b_data_out),
      .o_data_addr(b_data_addr), .o_data_valid(b_valid), .o_busy(b_busy),
      .o_done(b_done), .o_wrap_cnt(b_wrap));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   // Advances n falling edges and logs every data_valid of instance A.
   task automatic run_cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc_n++;
         if (a_valid) begin
            qa_addr.push_back(a_data_addr);
            qa_data.push_back(a_data_out);
            qa_wrap.push_back(a_wrap);
            qa_cyc.push_back(cyc_n);
         end
      end
   endtask

   task automatic clear_log();
      qa_addr.delete(); qa_data.delete(); qa_wrap.delete(); qa_cyc.delete();
   endtask

   task automatic do_start(input logic [1:0] m, input logic [2:0] sa, input logic [2:0] ea);
      mode = m; s_addr = sa; e_addr = ea; start = 1'b1;
      run_cyc(1);
      start = 1'b0;
   endtask

   initial begin
      int t0;
      logic [2:0] wseq [4];
      wseq = '{3'd6, 3'd7, 3'd0, 3'd1};

      // reset state
      run_cyc(1);
      chk("rst_mem_addr", 32'(a_mem_addr), 0);
      chk("rst_busy",     32'(a_busy), 0);
      chk("rst_done",     32'(a_done), 0);
      chk("rst_valid",    32'(a_valid), 0);
      chk("rst_wrap",     32'(a_wrap), 0);
      rst_n = 1'b1;
      run_cyc(2);

      // ONCE 2..5
      clear_log();
      t0 = cyc_n;
      do_start(2'd1, 3'd2, 3'd5);
      chk("once_busy", 32'(a_busy), 1);
      for (int i = 0; i < 40; i++) begin
         run_cyc(1);
         if (a_done) break;
      end
      chk("once_done", 32'(a_done), 1);
      chk("once_busy_end", 32'(a_busy), 0);
      chk("once_count", 32'(qa_addr.size()), 4);
      if (qa_cyc.size() > 0) chk("once_first_lat", 32'(qa_cyc[0] - t0), 6);
      for (int k = 0; k < qa_addr.size(); k++) begin
         chk($sformatf("once_addr%0d", k), 32'(qa_addr[k]), 32'(2 + k));
         chk($sformatf("once_data%0d", k), qa_data[k], 32'((2 + k) * 17));
         if (k > 0) chk($sformatf("once_gap%0d", k), 32'(qa_cyc[k] - qa_cyc[k-1]), 5);
      end
      chk("once_addr_held", 32'(a_mem_addr), 5);

      // WRAP 6..1 with a start pulse while busy that must be ignored
      clear_log();
      do_start(2'd0, 3'd6, 3'd1);
      chk("wrap_clr", 32'(a_wrap), 0);
      run_cyc(12);
      mode = 2'd1; s_addr = 3'd3; e_addr = 3'd3; start = 1'b1;
      run_cyc(1);
      start = 1'b0;
      run_cyc(46);
      chk("wrap_count", 32'(qa_addr.size()), 11);
      for (int k = 0; k < qa_addr.size(); k++) begin
         chk($sformatf("wrap_addr%0d", k), 32'(qa_addr[k]), 32'(wseq[k % 4]));
         chk($sformatf("wrap_data%0d", k), qa_data[k], mem_word(wseq[k % 4]));
         chk($sformatf("wrap_cnt%0d", k), 32'(qa_wrap[k]), 32'((k + 1) / 4));
      end
      stop = 1'b1;
      run_cyc(1);
      stop = 1'b0;
      chk("stop_busy", 32'(a_busy), 0);
      chk("stop_done", 32'(a_done), 0);
      chk("stop_wrap_hold", 32'(a_wrap), 2);

      // STEP 0..7: second step lands in WAIT and is dropped
      clear_log();
      do_start(2'd2, 3'd0, 3'd7);
      chk("step_wrap_clr", 32'(a_wrap), 0);
      run_cyc(10);
      chk("step_no_tick", 32'(qa_addr.size()), 0);
      step = 1'b1;
      run_cyc(2);
      step = 1'b0;
      run_cyc(3);
      step = 1'b1;
      run_cyc(1);
      step = 1'b0;
      run_cyc(5);
      chk("step_count", 32'(qa_addr.size()), 2);
      for (int k = 0; k < qa_addr.size(); k++) begin
         chk($sformatf("step_addr%0d", k), 32'(qa_addr[k]), 32'(k));
         chk($sformatf("step_data%0d", k), qa_data[k], 32'(k * 17));
      end
      chk("step_next_addr", 32'(a_mem_addr), 2);
      chk("step_busy", 32'(a_busy), 1);

      // stop together with start while in WAIT
      step = 1'b1;
      run_cyc(1);
      step = 1'b0;
      stop = 1'b1; start = 1'b1; mode = 2'd1; s_addr = 3'd5; e_addr = 3'd5;
      run_cyc(1);
      stop = 1'b0; start = 1'b0;
      chk("ss_busy", 32'(a_busy), 0);
      chk("ss_done", 32'(a_done), 0);
      run_cyc(6);
      chk("ss_no_valid", 32'(qa_addr.size()), 2);
      chk("ss_idle", 32'(a_busy), 0);
      chk("ss_data_hold", a_data_out, 32'h11);
      chk("ss_daddr_hold", 32'(a_data_addr), 1);

      // single-word scan
      clear_log();
      do_start(2'd1, 3'd7, 3'd7);
      run_cyc(12);
      chk("one_count", 32'(qa_addr.size()), 1);
      if (qa_addr.size() > 0) chk("one_addr", 32'(qa_addr[0]), 7);
      if (qa_data.size() > 0) chk("one_data", qa_data[0], 32'h77);
      chk("one_done", 32'(a_done), 1);
      chk("one_addr_held", 32'(a_mem_addr), 7);

      // asynchronous reset mid-run
      clear_log();
      do_start(2'd1, 3'd3, 3'd7);
      run_cyc(7);
      chk("pre_rst_data", a_data_out, 32'h33);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_mem_addr", 32'(a_mem_addr), 0);
      chk("arst_data", a_data_out, 0);
      chk("arst_daddr", 32'(a_data_addr), 0);
      chk("arst_valid", 32'(a_valid), 0);
      chk("arst_busy", 32'(a_busy), 0);
      chk("arst_done", 32'(a_done), 0);
      run_cyc(1);
      rst_n = 1'b1;
      clear_log();
      run_cyc(10);
      chk("post_rst_no_valid", 32'(qa_addr.size()), 0);
      chk("post_rst_busy", 32'(a_busy), 0);
      chk("post_rst_addr", 32'(a_mem_addr), 0);

      // DIV=1, MEM_LAT=3 instance, ONCE 5..6
      mode = 2'd1; s_addr = 3'd5; e_addr = 3'd6; start = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         run_cyc(1);
         if (i == 1) start = 1'b0;
         chk($sformatf("b_valid_c%0d", i), 32'(b_valid), 32'((i == 5 || i == 9) ? 1 : 0));
         chk($sformatf("b_addr_c%0d", i), 32'(b_mem_addr), (i <= 4) ? 32'd5 : 32'd6);
         if (b_valid) begin
            chk($sformatf("b_data_c%0d", i), b_data_out, (i == 5) ? 32'h55 : 32'h66);
            chk($sformatf("b_daddr_c%0d", i), 32'(b_data_addr), (i == 5) ? 32'd5 : 32'd6);
         end
      end
      chk("b_done", 32'(b_done), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
